mem_region_ctrl: RTL
====================

// Module: mem_region_ctrl
// PURPOSE
//  Parametrised multi-region memory controller between the CPU load/store port and N memory/peripheral targets.
//  Decodes the CPU address against a base/mask table and forwards one access at a time to the selected region.
//  Adds a req/ready/done handshake, per-region wait-state support via target ready and per-region read-only protection.
//  Reports a registered error response; replaces the combinational single-cycle controller.
// PARAMETERS
//  AW            32                 address width
//  DW            32                 data width
//  N_REGIONS     4                  number of target regions
//  REGION_BASE   {40000000,20000000,10000000,00000000}   N*AW flat; region i base at [i*AW+:AW]
//  REGION_MASK   {FFFFF000,FFFFF000,FFFF0000,FFFF0000}   N*AW flat; addr&mask==base -> hit
//  REGION_RO     4'b0100            bit i set: region i is read-only (region 2 = flash)
//  TIMEOUT_CYC   256                target-ready timeout; used only with MEM_REGION_CTRL_TIMEOUT_EN
// PORTS
//  clk           in   1       clock
//  rst           in   1       asynchronous reset, active high
//  cpu_req       in   1       access request; sampled only while cpu_ready=1
//  cpu_we        in   1       1=write, 0=read
//  cpu_addr      in   AW      byte address
//  cpu_wdata     in   DW      write data
//  cpu_ready     out  1       controller idle, request accepted this cycle if cpu_req=1
//  cpu_done      out  1       one-cycle completion pulse
//  cpu_rdata     out  DW      read data, valid with cpu_done on successful read
//  cpu_error     out  1       error flag, valid with cpu_done
//  tgt_rd_en     out  N       per-region read strobe (one-hot or zero)
//  tgt_wr_en     out  N       per-region write strobe (one-hot or zero)
//  tgt_addr      out  AW      region offset = cpu_addr & ~REGION_MASK[i]
//  tgt_wdata     out  DW      write data to targets (shared)
//  tgt_rdata     in   N*DW    per-region read data, flat
//  tgt_ready     in   N       per-region completion; 1 = access done this cycle
// BEHAVIOUR
//  Reset (async, active high): state=IDLE; cpu_ready=1; cpu_done=0; cpu_rdata=0; cpu_error=0; tgt_* strobes=0; tgt_addr/wdata=0.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE; decode error: IDLE -> RESP.
//   IDLE:   cpu_ready=1. On cpu_req: decode; latch we, offset, wdata, region index.
//           No hit, or write to RO region -> latch error=1, go RESP (no target strobe ever issued).
//           Hit -> go ACCESS.
//   ACCESS: cpu_ready=0; drive tgt_rd_en[i] or tgt_wr_en[i] every cycle until tgt_ready[i]=1.
//           On tgt_ready[i]: capture tgt_rdata[i*DW+:DW] (reads only), error=0, go RESP. Strobes drop next cycle.
//           tgt_ready of unselected regions ignored.
//   RESP:   cpu_done=1 for exactly one cycle with cpu_rdata/cpu_error; go IDLE. cpu_rdata holds until next done.
//  Latency: req accepted cycle 0; ACCESS from cycle 1; tgt_ready in cycle k>=1 -> cpu_done cycle k+1. Min 2 cycles.
//  Decode error: cpu_done at cycle 1, cpu_error=1, cpu_rdata unchanged.
//  Overlapping regions: lowest index wins (fixed priority).
//  cpu_req while cpu_ready=0 is ignored; not queued. Back-to-back: new req accepted in the cycle after cpu_done.
//  Write: cpu_rdata not updated. Reset mid-ACCESS: strobes deassert immediately (async), no done pulse.
// CONFIGURATION
//  MEM_REGION_CTRL_TIMEOUT_EN defined: cycle counter (clog2(TIMEOUT_CYC+1) bits) cleared on ACCESS entry, +1 per ACCESS cycle;
//   reaching TIMEOUT_CYC without tgt_ready -> strobes drop, error=1, go RESP. tgt_ready in the same cycle wins (success).
//  Undefined: no counter; ACCESS waits for tgt_ready indefinitely.
// STRUCTURE
//  Package mem_region_pkg: state enum {IDLE,ACCESS,RESP}, default base/mask/RO constants, region index width function.
//  Sub-module mem_region_decoder: combinational addr -> hit, one-hot select, index, ro; lowest-index priority.
//  FSM, latches and optional timeout counter in mem_region_ctrl.
// TESTING
//  Read 0x0000_0010, tgt_ready[0] same cycle as ACCESS, rdata0=0xDEADBEEF -> cpu_done cycle 2, rdata=0xDEADBEEF, error=0, tgt_addr=0x10.
//  Write 0x1000_0004 data 0x12345678, tgt_ready[1] after 3 wait cycles -> tgt_wr_en=4'b0010 for 4 cycles, done cycle 5, error=0.
//  Write 0x2000_0000 (RO flash) -> no strobe, done cycle 1, error=1; read same addr -> normal completion.
//  Read 0x8000_0000 (no hit) -> no strobe, done cycle 1, error=1, cpu_rdata unchanged.
//  cpu_req held high during ACCESS, tgt_ready[3] asserted (wrong region) -> ignored; only tgt_ready[1] completes.
//  TIMEOUT_EN, TIMEOUT_CYC=8, tgt_ready never -> done with error=1 at cycle 9; rst pulsed mid-ACCESS -> strobes 0, cpu_ready=1.

Source files
------------

// File: rtl/mem_region_pkg.sv
// Shared types and default configuration for the multi-region memory controller.
// Holds the FSM state encoding, the default region table and a helper that
// sizes the region index for a given number of regions.
package mem_region_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEFAULT_AW        = 32;
  localparam int DEFAULT_DW        = 32;
  localparam int DEFAULT_N_REGIONS = 4;

  // Region i lives at bits [i*AW +: AW]; region 0 is the rightmost word.
  localparam logic [DEFAULT_N_REGIONS*DEFAULT_AW-1:0] DEFAULT_REGION_BASE =
    {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};

  localparam logic [DEFAULT_N_REGIONS*DEFAULT_AW-1:0] DEFAULT_REGION_MASK =
    {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};

  // Region 2 is the flash window and may only be read.
  localparam logic [DEFAULT_N_REGIONS-1:0] DEFAULT_REGION_RO = 4'b0100;

  localparam int DEFAULT_TIMEOUT_CYC = 256;

  // Width of a region index; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_region_decoder.sv
// Combinational address decoder for the region table.
// A region hits when (addr & mask) == base. When several regions overlap the
// lowest index is selected. Also reports the read-only attribute and the
// offset of the address inside the selected region.
module mem_region_decoder
  import mem_region_pkg::*;
#(
  parameter int                          AW          = DEFAULT_AW,
  parameter int                          N_REGIONS   = DEFAULT_N_REGIONS,
  parameter logic [N_REGIONS*AW-1:0]     REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [N_REGIONS*AW-1:0]     REGION_MASK = DEFAULT_REGION_MASK,
  parameter logic [N_REGIONS-1:0]        REGION_RO   = DEFAULT_REGION_RO
) (
  input  logic [AW-1:0]                     addr_i,
  output logic                              hit_o,
  output logic [N_REGIONS-1:0]              sel_o,
  output logic [idxWidth(N_REGIONS)-1:0]    idx_o,
  output logic                              ro_o,
  output logic [AW-1:0]                     offset_o
);

  localparam int IW = idxWidth(N_REGIONS);

  // Scan from the highest index down so the lowest matching region is the last to overwrite the result.
  always_comb begin
    hit_o    = 1'b0;
    sel_o    = '0;
    idx_o    = '0;
    ro_o     = 1'b0;
    offset_o = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if ((addr_i & REGION_MASK[i*AW +: AW]) == REGION_BASE[i*AW +: AW]) begin
        hit_o    = 1'b1;
        sel_o    = '0;
        sel_o[i] = 1'b1;
        idx_o    = IW'(i);
        ro_o     = REGION_RO[i];
        offset_o = addr_i & ~REGION_MASK[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/mem_region_ctrl.sv
// Multi-region memory controller between the CPU load/store port and N targets.
// One access is in flight at a time: IDLE accepts and decodes a request,
// ACCESS strobes the selected target until it signals ready, RESP returns a
// one-cycle done pulse with read data and an error flag. Unmapped addresses and
// writes to read-only regions go straight to RESP with the error flag set.
// Optional feature: define MEM_REGION_CTRL_TIMEOUT_EN to abort an ACCESS that
// has not seen target ready within TIMEOUT_CYC cycles (reported as an error).
module mem_region_ctrl
  import mem_region_pkg::*;
#(
  parameter int                          AW          = DEFAULT_AW,
  parameter int                          DW          = DEFAULT_DW,
  parameter int                          N_REGIONS   = DEFAULT_N_REGIONS,
  parameter logic [N_REGIONS*AW-1:0]     REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [N_REGIONS*AW-1:0]     REGION_MASK = DEFAULT_REGION_MASK,
  parameter logic [N_REGIONS-1:0]        REGION_RO   = DEFAULT_REGION_RO,
  parameter int                          TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [AW-1:0]             cpu_addr,
  input  logic [DW-1:0]             cpu_wdata,
  output logic                      cpu_ready,
  output logic                      cpu_done,
  output logic [DW-1:0]             cpu_rdata,
  output logic                      cpu_error,
  output logic [N_REGIONS-1:0]      tgt_rd_en,
  output logic [N_REGIONS-1:0]      tgt_wr_en,
  output logic [AW-1:0]             tgt_addr,
  output logic [DW-1:0]             tgt_wdata,
  input  logic [N_REGIONS*DW-1:0]   tgt_rdata,
  input  logic [N_REGIONS-1:0]      tgt_ready
);

  localparam int IW = idxWidth(N_REGIONS);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [N_REGIONS-1:0]   sel_q, sel_d;
  logic [AW-1:0]          tgtAddr_q, tgtAddr_d;
  logic [DW-1:0]          wdata_q, wdata_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic                   error_q, error_d;

  logic                   decHit;
  logic [N_REGIONS-1:0]   decSel;
  logic [IW-1:0]          decIdx;
  logic                   decRo;
  logic [AW-1:0]          decOffset;

  logic [DW-1:0]          selRdata;
  logic                   tgtDone;
  logic                   timeoutHit;

  mem_region_decoder #(
    .AW          (AW),
    .N_REGIONS   (N_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_RO   (REGION_RO)
  ) u_decoder (
    .addr_i   (cpu_addr),
    .hit_o    (decHit),
    .sel_o    (decSel),
    .idx_o    (decIdx),
    .ro_o     (decRo),
    .offset_o (decOffset)
  );

  // Pick the read data of the latched region and see whether that region (and only that one) is ready.
  always_comb begin
    selRdata = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (idx_q == IW'(i)) begin
        selRdata = tgt_rdata[i*DW +: DW];
      end
    end
    tgtDone = |(tgt_ready & sel_q);
  end

`ifdef MEM_REGION_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Access-cycle counter: zero on ACCESS entry, one step per ACCESS cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == ACCESS) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // The counter holds the number of ACCESS cycles already completed, so the
  // current cycle is the TIMEOUT_CYC-th one when it equals TIMEOUT_CYC-1.
  assign timeoutHit = (state_q == ACCESS) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the timeout option ACCESS waits for target ready forever; the
  // comparison below is constant false and only ties off the parameter.
  assign timeoutHit = (TIMEOUT_CYC < 0);
`endif

  // State and datapath registers; reset returns to IDLE with all latched fields cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      idx_q     <= '0;
      sel_q     <= '0;
      tgtAddr_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      tgtAddr_q <= tgtAddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic: accept and decode in IDLE, wait on the selected target in ACCESS, one RESP cycle.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    tgtAddr_d = tgtAddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d      = cpu_we;
          idx_d     = decIdx;
          tgtAddr_d = decOffset;
          wdata_d   = cpu_wdata;
          if (!decHit || (cpu_we && decRo)) begin
            sel_d   = '0;
            error_d = 1'b1;
            state_d = RESP;
          end else begin
            sel_d   = decSel;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (tgtDone) begin
          if (!we_q) begin
            rdata_d = selRdata;
          end
          error_d = 1'b0;
          state_d = RESP;
        end else if (timeoutHit) begin
          error_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state; strobes exist only while in ACCESS.
  always_comb begin
    cpu_ready = (state_q == IDLE);
    cpu_done  = (state_q == RESP);
    tgt_rd_en = '0;
    tgt_wr_en = '0;
    if (state_q == ACCESS) begin
      if (we_q) begin
        tgt_wr_en = sel_q;
      end else begin
        tgt_rd_en = sel_q;
      end
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_error = error_q;
  assign tgt_addr  = tgtAddr_q;
  assign tgt_wdata = wdata_q;

endmodule
